// File: rtl/countdown_bcd_timer.sv
// MM:SS round-clock countdown with its own rate divider, run/pause FSM, BCD borrow chain and expiry strobe.
// All outputs come straight from registers, so there is no input-to-output path and no backpressure.
module countdown_bcd_timer #(
  parameter int unsigned TICK_DIV = 50000000,
  parameter logic [15:0] INIT_BCD = 16'h0100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] load_value,
  input  logic        start,
  input  logic        pause,
  output logic [15:0] digits,
  output logic        running,
  output logic        expired,
  output logic        done_pulse
);

  localparam int DW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSED, S_EXPIRED} state_t;

  state_t          r_state;
  logic [15:0]     r_digits;
  logic [DW-1:0]   r_div;
  logic            r_done;

  logic [15:0]     w_clamped;
  logic [15:0]     w_dec;
  logic            w_go;
  logic            w_hold;
  logic            w_div_last;

  // Simultaneous start and pause counts as neither.
  assign w_go       = start & ~pause;
  assign w_hold     = pause & ~start;
  assign w_div_last = (r_div == DW'(TICK_DIV - 1));

  always_comb begin
    w_clamped[15:12] = (load_value[15:12] > 4'd9) ? 4'd9 : load_value[15:12];
    w_clamped[11:8]  = (load_value[11:8]  > 4'd9) ? 4'd9 : load_value[11:8];
    w_clamped[7:4]   = (load_value[7:4]   > 4'd5) ? 4'd5 : load_value[7:4];
    w_clamped[3:0]   = (load_value[3:0]   > 4'd9) ? 4'd9 : load_value[3:0];
  end

  // Borrow chain; never reached with 0000 since RUN is only entered with a nonzero value.
  always_comb begin
    w_dec = r_digits;
    if (r_digits[3:0] != 4'd0) begin
      w_dec[3:0] = r_digits[3:0] - 4'd1;
    end else begin
      w_dec[3:0] = 4'd9;
      if (r_digits[7:4] != 4'd0) begin
        w_dec[7:4] = r_digits[7:4] - 4'd1;
      end else begin
        w_dec[7:4] = 4'd5;
        if (r_digits[11:8] != 4'd0) begin
          w_dec[11:8] = r_digits[11:8] - 4'd1;
        end else begin
          w_dec[11:8]  = 4'd9;
          w_dec[15:12] = r_digits[15:12] - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_digits <= INIT_BCD;
      r_div    <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (load) begin
        r_state  <= S_IDLE;
        r_div    <= '0;
        r_digits <= w_clamped;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_go) begin
              if (r_digits != 16'h0000) begin
                r_state <= S_RUN;
                r_div   <= '0;
              end else begin
                r_state <= S_EXPIRED;
                r_done  <= 1'b1;
              end
            end
          end
          S_RUN: begin
            if (w_hold) begin
              r_state <= S_PAUSED;
            end else if (w_div_last) begin
              r_div    <= '0;
              r_digits <= w_dec;
              if (w_dec == 16'h0000) begin
                r_state <= S_EXPIRED;
                r_done  <= 1'b1;
              end
            end else begin
              r_div <= r_div + DW'(1);
            end
          end
          S_PAUSED: begin
            // Divider is left untouched so the partial second survives the pause.
            if (w_go) r_state <= S_RUN;
          end
          S_EXPIRED: begin
            r_digits <= 16'h0000;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign digits     = r_digits;
  assign running    = (r_state == S_RUN);
  assign expired    = (r_state == S_EXPIRED);
  assign done_pulse = r_done;

endmodule

// File: tb/tb_countdown_bcd_timer.sv
// Bench for countdown_bcd_timer: seconds-based reference model feeds a scoreboard queue; a monitor compares every cycle.
module tb_countdown_bcd_timer;

  localparam int unsigned TICK_DIV = 4;
  localparam logic [15:0] INIT_BCD = 16'h0100;

  typedef struct packed {
    logic [15:0] d;
    logic        run;
    logic        exp;
    logic        done;
  } obs_t;

  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_EXPIRED = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load = 1'b0;
  logic [15:0] load_value = 16'h0000;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic [15:0] digits;
  logic        running;
  logic        expired;
  logic        done_pulse;

  int checks = 0;
  int errors = 0;
  obs_t sb[$];

  int m_state;
  int m_secs;
  int m_phase;
  bit m_done;

  countdown_bcd_timer #(.TICK_DIV(TICK_DIV), .INIT_BCD(INIT_BCD)) dut (
    .clk(clk), .reset(reset), .load(load), .load_value(load_value),
    .start(start), .pause(pause), .digits(digits), .running(running),
    .expired(expired), .done_pulse(done_pulse)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int secs);
    int mm, ss;
    mm = secs / 60;
    ss = secs % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  function automatic int min_int(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    o.d    = to_bcd(m_secs);
    o.run  = (m_state == M_RUN);
    o.exp  = (m_state == M_EXPIRED);
    o.done = m_done;
    return o;
  endfunction

  task automatic model_reset();
    m_state = M_IDLE;
    m_secs  = 60;
    m_phase = 0;
    m_done  = 1'b0;
  endtask

  task automatic model_step(input bit ld, input logic [15:0] lv, input bit st, input bit ps);
    int mt, mo, s10, s1;
    m_done = 1'b0;
    if (ld) begin
      mt  = min_int(int'(lv[15:12]), 9);
      mo  = min_int(int'(lv[11:8]), 9);
      s10 = min_int(int'(lv[7:4]), 5);
      s1  = min_int(int'(lv[3:0]), 9);
      m_secs  = (mt * 10 + mo) * 60 + s10 * 10 + s1;
      m_state = M_IDLE;
      m_phase = 0;
    end else if (m_state == M_IDLE) begin
      if (st && !ps) begin
        if (m_secs > 0) begin
          m_state = M_RUN;
          m_phase = 0;
        end else begin
          m_state = M_EXPIRED;
          m_done  = 1'b1;
        end
      end
    end else if (m_state == M_RUN) begin
      if (ps && !st) begin
        m_state = M_PAUSED;
      end else begin
        m_phase++;
        if (m_phase == TICK_DIV) begin
          m_phase = 0;
          m_secs--;
          if (m_secs == 0) begin
            m_state = M_EXPIRED;
            m_done  = 1'b1;
          end
        end
      end
    end else if (m_state == M_PAUSED) begin
      if (st && !ps) m_state = M_RUN;
    end
  endtask

  task automatic cyc(input bit ld, input logic [15:0] lv, input bit st, input bit ps);
    @(negedge clk);
    load       = ld;
    load_value = lv;
    start      = st;
    pause      = ps;
    model_step(ld, lv, st, ps);
    sb.push_back(model_obs());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 16'h0000, 1'b0, 1'b0);
  endtask

  // Reset lands mid-cycle; the outputs must change before any clock edge.
  task automatic reset_mid(input string name);
    obs_t got;
    @(negedge clk);
    load  = 1'b0;
    start = 1'b0;
    pause = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    got = {digits, running, expired, done_pulse};
    checks++;
    if (got !== {INIT_BCD, 3'b000}) begin
      errors++;
      $display("FAIL %s: got %h/%b%b%b, expected %h/000", name, got.d, got.run, got.exp, got.done, INIT_BCD);
    end
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin : monitor
    obs_t got, exp;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        exp = sb.pop_front();
        got = {digits, running, expired, done_pulse};
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL cycle@%0t: got digits=%h run=%b exp=%b done=%b, expected digits=%h run=%b exp=%b done=%b",
                   $time, got.d, got.run, got.exp, got.done, exp.d, exp.run, exp.exp, exp.done);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin : driver
    bit st, ps;
    logic [15:0] lv;
    int r;
    model_reset();
    #3;
    reset_mid("reset_initial");

    cyc(1'b1, 16'h0203, 1'b0, 1'b0);
    idle(2);

    cyc(1'b1, 16'h1000, 1'b0, 1'b0);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0);
    idle(9);

    cyc(1'b1, 16'h0002, 1'b0, 1'b0);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0);
    idle(10);
    for (int i = 0; i < 3; i++) cyc(1'b0, 16'h0000, 1'b1, 1'b0);
    cyc(1'b0, 16'h0000, 1'b0, 1'b1);
    idle(2);

    cyc(1'b1, 16'h0010, 1'b0, 1'b0);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0);
    idle(2);
    for (int i = 0; i < 20; i++) cyc(1'b0, 16'h0000, 1'b0, 1'b1);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0);
    idle(3);

    cyc(1'b1, 16'hAB7F, 1'b1, 1'b0);
    idle(2);
    cyc(1'b1, 16'h0000, 1'b0, 1'b0);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0);
    idle(3);

    cyc(1'b1, 16'h0042, 1'b0, 1'b0);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0);
    cyc(1'b0, 16'h0000, 1'b1, 1'b1);
    cyc(1'b0, 16'h0000, 1'b1, 1'b1);
    idle(2);
    reset_mid("reset_mid_run");

    cyc(1'b1, 16'h9959, 1'b0, 1'b0);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0);
    idle(5);

    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 199);
      if (r < 6) begin
        lv = 16'($urandom);
        if (r < 3) lv = {12'h000, 4'($urandom_range(0, 3))};
        cyc(1'b1, lv, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else if (r == 6) begin
        reset_mid("reset_random");
      end else begin
        st = ($urandom_range(0, 99) < 40);
        ps = ($urandom_range(0, 99) < 15);
        cyc(1'b0, 16'h0000, st, ps);
      end
    end

    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/countdown_bcd_timer.md
Name: countdown_bcd_timer

Overview:
- Sequential MM:SS countdown timer for the game's round clock.
- Produces four 4-bit BCD digits, each wired directly to the 4-bit input of one hex-to-7-segment decoder instance (HEX3..HEX0).
- Contains its own rate divider, run/pause state machine, BCD borrow chain and expiry pulse.
- Sits directly upstream of the display decoders; also feeds the game FSM through the expired and done_pulse outputs.

Parameters:
- TICK_DIV, 50000000: clk cycles per one-second decrement. Minimum 2. Sim benches use 4.
- INIT_BCD, 16'h0100: digit value loaded at reset (01:00), format {min_tens, min_ones, sec_tens, sec_ones}.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- load  in  1  synchronous load of load_value; highest priority.
- load_value  in  16  BCD {min_tens, min_ones, sec_tens, sec_ones}.
- start  in  1  level; begin or resume counting.
- pause  in  1  level; suspend counting.
- digits  out  16  current BCD value, same format as load_value. [3:0]=sec_ones feeds the HEX0 decoder, up to [15:12]=min_tens feeding HEX3.
- running  out  1  high while in RUN.
- expired  out  1  high while in EXPIRED.
- done_pulse  out  1  single-cycle strobe on entry to EXPIRED.

Behaviour:
- All outputs registered. No combinational path from inputs to outputs.
- Reset (asynchronous, immediate, any time, including mid-count):
  - state=IDLE, digits=INIT_BCD, divider=0.
  - running=0, expired=0, done_pulse=0.
- States: IDLE, RUN, PAUSED, EXPIRED.
- Load, evaluated first, in any state:
  - Next state=IDLE, divider=0.
  - digits = load_value after clamping: any digit >9 becomes 9; sec_tens >5 becomes 5.
  - start and pause are ignored in that cycle.
- IDLE:
  - start=1, pause=0, digits!=0000 -> RUN, divider=0.
  - start=1, pause=0, digits==0000 -> EXPIRED.
- RUN:
  - pause=1, start=0 -> PAUSED. The divider holds its count; no decrement that cycle.
  - Otherwise the divider increments. When divider==TICK_DIV-1 it wraps to 0 and a tick fires.
- PAUSED:
  - start=1, pause=0 -> RUN. The divider resumes from its held value, so a partial second is preserved.
- EXPIRED:
  - Digits hold 0000.
  - start and pause are ignored; only load or reset leaves this state.
- start and pause both high in the same cycle: no state change. In RUN, counting continues.
- Tick decrement (BCD borrow chain):
  - sec_ones 0 -> 9 and borrows; otherwise it decrements.
  - sec_tens 0 -> 5 and borrows.
  - min_ones 0 -> 9 and borrows.
  - min_tens decrements on borrow.
  - Example: 10:00 -> 09:59. 01:00 -> 00:59.
- Expiry:
  - The tick that takes the value 00:01 -> 00:00 also moves the state to EXPIRED.
  - On the following edge: digits=0000, expired=1, running=0, done_pulse=1 for exactly one cycle.
  - The same registered timing applies to the IDLE -> EXPIRED path when start is given with digits==0000.
- Digits never underflow below 0000 and never show a non-BCD nibble.
- Output timing:
  - running and expired reflect the registered state.
  - done_pulse is never asserted in two consecutive cycles.
- Max value 99:59. No upper wrap is needed, since the timer only counts down.

Test Plan (TICK_DIV=4):
1. Reset and load:
   - Assert reset mid-cycle -> digits=16'h0100, IDLE, all flags 0, with no clock edge required.
   - load_value=16'h0203, load one cycle -> digits=16'h0203.
2. Run and borrow:
   - Load 16'h1000, start -> after 4 clk digits=16'h0959, after 8 clk 16'h0958.
   - running=1 throughout.
3. Expiry:
   - Load 16'h0002, start -> 16'h0001 after 4 clk, 16'h0000 after 8 clk.
   - expired=1 and done_pulse=1 for one cycle only.
   - Further start is ignored; digits stay 0000.
4. Pause and resume:
   - Load 16'h0010, start, pause after 2 clk, hold 20 clk -> digits stay 16'h0010.
   - start -> digits=16'h0009 exactly 2 clk later (partial second preserved).
5. Clamp and priority:
   - load_value=16'hAB7F with load and start together -> digits=16'h9959, IDLE, running=0.
   - Load 16'h0000 then start -> EXPIRED with one done_pulse.
6. Simultaneous inputs and reset mid-run:
   - start and pause both high in RUN -> counting continues.
   - reset asserted during RUN at 16'h0041 -> digits=16'h0100 and IDLE immediately.
